// File: rtl/rom_link_pkg.sv
// Shared constants and helpers for both ends of the bit-serial ROM bus.
package rom_link_pkg;

  localparam int WORD_LEN = 56;
  localparam int ADR_W    = 8;
  localparam int INST_W   = 10;
  localparam int BT_W     = 6;

  localparam logic [BT_W-1:0] BT_T11       = 6'd11;
  localparam logic [BT_W-1:0] BT_ADR_LOAD  = 6'd18;
  localparam logic [BT_W-1:0] BT_ADR_FIRST = 6'd19;
  localparam logic [BT_W-1:0] BT_ADR_LAST  = 6'd26;
  localparam logic [BT_W-1:0] BT_IS_FIRST  = 6'd45;
  localparam logic [BT_W-1:0] BT_IS_LAST   = 6'd54;
  localparam logic [BT_W-1:0] BT_LAST      = 6'd55;

  typedef enum logic [1:0] {
    PC_HOLD = 2'd0,
    PC_INC  = 2'd1,
    PC_JUMP = 2'd2
  } pc_op_e;

  // Jump outranks run so a halted sequencer can still be redirected.
  function automatic pc_op_e pc_op_sel(input logic jv, input logic run_en);
    pc_op_e op;
    if (jv) begin
      op = PC_JUMP;
    end else if (run_en) begin
      op = PC_INC;
    end else begin
      op = PC_HOLD;
    end
    return op;
  endfunction

  function automatic logic bt_in_window(input logic [BT_W-1:0] bt,
                                        input logic [BT_W-1:0] lo,
                                        input logic [BT_W-1:0] hi);
    return (bt >= lo) && (bt <= hi);
  endfunction

endpackage

// File: rtl/ct_rom_link_word_timer.sv
// Word timer: 0..55 bit-time counter plus the window decodes both bus ends need.
module word_timer
  import rom_link_pkg::*;
(
  input  logic            cph2,
  input  logic            pon,
  output logic [BT_W-1:0] bt,
  output logic            te_adr,
  output logic            te_is,
  output logic            te_t11,
  output logic            te_load,
  output logic            te_last
);

  logic [BT_W-1:0] bt_r;

  // Bit-time counter, wraps at the last bit of the word.
  always_ff @(posedge cph2) begin
    if (pon) begin
      bt_r <= 6'd0;
    end else if (bt_r == BT_LAST) begin
      bt_r <= 6'd0;
    end else begin
      bt_r <= bt_r + 6'd1;
    end
  end

  assign bt      = bt_r;
  assign te_adr  = bt_in_window(bt_r, BT_ADR_FIRST, BT_ADR_LAST);
  assign te_is   = bt_in_window(bt_r, BT_IS_FIRST, BT_IS_LAST);
  assign te_t11  = (bt_r == BT_T11);
  assign te_load = (bt_r == BT_ADR_LOAD);
  assign te_last = (bt_r == BT_LAST);

endmodule

// File: rtl/ct_rom_link.sv
// Control/timing end of the serial ROM bus: sends the PC on ia, collects the
// instruction from is, and advances/holds/jumps the PC once per word.
module ct_rom_link
  import rom_link_pkg::*;
(
  input  logic              cph2,
  input  logic              pon,
  input  logic              run,
  input  logic              jmp_valid,
  input  logic [ADR_W-1:0]  jmp_addr,
  output logic              jmp_ack,
  output logic              ia,
  input  logic              is,
  output logic              sync,
  output logic [BT_W-1:0]   bit_time,
  output logic [ADR_W-1:0]  pc,
  output logic [INST_W-1:0] inst,
  output logic              inst_valid,
  output logic              flag_t11
);

  logic [BT_W-1:0]   bt_s;
  logic              te_adr_s;
  logic              te_is_s;
  logic              te_t11_s;
  logic              te_load_s;
  logic              te_last_s;

  logic [ADR_W-1:0]  adr_sr_r;
  logic [INST_W-1:0] inst_sr_r;
  logic [INST_W-1:0] inst_r;
  logic              inst_valid_r;
  logic              flag_t11_r;
  logic [ADR_W-1:0]  pc_r;
  logic              jmp_ack_r;
  logic [ADR_W-1:0]  pc_nxt_s;
  pc_op_e            pc_op_s;

  word_timer u_word_timer (
    .cph2    (cph2),
    .pon     (pon),
    .bt      (bt_s),
    .te_adr  (te_adr_s),
    .te_is   (te_is_s),
    .te_t11  (te_t11_s),
    .te_load (te_load_s),
    .te_last (te_last_s)
  );

  // Address shifter: captures pc before the send window, then shifts LSB first.
  always_ff @(posedge cph2) begin
    if (pon) begin
      adr_sr_r <= 8'h00;
    end else if (te_load_s) begin
      adr_sr_r <= pc_r;
    end else if (te_adr_s) begin
      adr_sr_r <= {1'b0, adr_sr_r[ADR_W-1:1]};
    end else begin
      adr_sr_r <= adr_sr_r;
    end
  end

  // Instruction deserialiser: first bit received ends up in bit 0.
  always_ff @(posedge cph2) begin
    if (pon) begin
      inst_sr_r <= 10'h000;
    end else if (te_is_s) begin
      inst_sr_r <= {is, inst_sr_r[INST_W-1:1]};
    end else begin
      inst_sr_r <= inst_sr_r;
    end
  end

  // Commit of the received word and the t11 status sample.
  always_ff @(posedge cph2) begin
    if (pon) begin
      inst_r       <= 10'h000;
      inst_valid_r <= 1'b0;
      flag_t11_r   <= 1'b0;
    end else begin
      inst_valid_r <= te_last_s;
      inst_r       <= te_last_s ? inst_sr_r : inst_r;
      flag_t11_r   <= te_t11_s ? is : flag_t11_r;
    end
  end

  // Next-PC selection; only consulted at the word boundary.
  always_comb begin
    pc_op_s  = pc_op_sel(jmp_valid, run);
    pc_nxt_s = pc_r;
    case (pc_op_s)
      PC_JUMP: pc_nxt_s = jmp_addr;
      PC_INC:  pc_nxt_s = pc_r + 8'd1;
      PC_HOLD: pc_nxt_s = pc_r;
      default: pc_nxt_s = pc_r;
    endcase
  end

  // Program counter and jump acknowledge, updated once per word.
  always_ff @(posedge cph2) begin
    if (pon) begin
      pc_r      <= 8'h00;
      jmp_ack_r <= 1'b0;
    end else if (te_last_s) begin
      pc_r      <= pc_nxt_s;
      jmp_ack_r <= jmp_valid;
    end else begin
      pc_r      <= pc_r;
      jmp_ack_r <= 1'b0;
    end
  end

  // ia and sync decode only registered state, so they cannot glitch on inputs.
  assign ia         = te_adr_s & adr_sr_r[0];
  assign sync       = ~te_last_s;
  assign bit_time   = bt_s;
  assign pc         = pc_r;
  assign inst       = inst_r;
  assign inst_valid = inst_valid_r;
  assign flag_t11   = flag_t11_r;
  assign jmp_ack    = jmp_ack_r;

endmodule

// File: tb/tb_ct_rom_link.sv
// Directed bench for ct_rom_link: bench-side ROM drives is, captures ia per word.
module tb_ct_rom_link;
  import rom_link_pkg::*;

  logic        cph2 = 1'b0;
  logic        pon = 1'b1;
  logic        run = 1'b0;
  logic        jmp_valid = 1'b0;
  logic [7:0]  jmp_addr = 8'h00;
  logic        is = 1'b0;
  logic        jmp_ack;
  logic        ia;
  logic        sync;
  logic [5:0]  bit_time;
  logic [7:0]  pc;
  logic [9:0]  inst;
  logic        inst_valid;
  logic        flag_t11;

  int          n_vec = 0;
  int          n_err = 0;
  int          exp_bt = 0;
  int          tm_err = 0;
  logic [7:0]  ia_cap;
  logic        iv_at1, ack_at1, flag_at11, flag_at12;
  logic [9:0]  hold_roms [3];

  ct_rom_link dut (
    .cph2(cph2), .pon(pon), .run(run), .jmp_valid(jmp_valid),
    .jmp_addr(jmp_addr), .jmp_ack(jmp_ack), .ia(ia), .is(is),
    .sync(sync), .bit_time(bit_time), .pc(pc), .inst(inst),
    .inst_valid(inst_valid), .flag_t11(flag_t11)
  );

  always #5 cph2 = ~cph2;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One clock; the bench keeps its own bit-time model.
  task automatic cyc();
    @(posedge cph2);
    if (pon) exp_bt = 0;
    else if (exp_bt == 55) exp_bt = 0;
    else exp_bt++;
    @(negedge cph2);
  endtask

  // Full word from bt 0 to the next bt 0. jmode: 0 none, 1 held bt 50..55, 2 pulse at bt 30.
  task automatic run_word(input logic [9:0] rom, input logic t11, input int jmode,
                          input logic [7:0] jaddr);
    ia_cap = 8'h00;
    tm_err = 0;
    for (int b = 0; b < 56; b++) begin
      if (b == 11) is = t11;
      else if (b >= 45 && b <= 54) is = rom[b-45];
      else is = 1'b0;
      jmp_valid = (jmode == 1 && b >= 50) || (jmode == 2 && b == 30);
      jmp_addr  = jaddr;
      if (bit_time !== 6'(exp_bt)) tm_err++;
      if (exp_bt != b) tm_err++;
      if (sync !== (exp_bt != 55)) tm_err++;
      if (b >= 19 && b <= 26) ia_cap[b-19] = ia;
      else if (ia !== 1'b0) tm_err++;
      if (b == 1) begin
        iv_at1  = inst_valid;
        ack_at1 = jmp_ack;
      end
      if (b == 11) flag_at11 = flag_t11;
      if (b == 12) flag_at12 = flag_t11;
      cyc();
    end
    is = 1'b0;
    jmp_valid = 1'b0;
    chk("timing", tm_err, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    hold_roms[0] = 10'h155;
    hold_roms[1] = 10'h0AA;
    hold_roms[2] = 10'h3FF;

    pon = 1'b1;
    cyc();
    cyc();
    pon = 1'b0;
    chk("rst_bt", bit_time, 0);
    chk("rst_pc", pc, 8'h00);
    chk("rst_inst", inst, 10'h000);
    chk("rst_iv", inst_valid, 1'b0);
    chk("rst_ack", jmp_ack, 1'b0);
    chk("rst_ia", ia, 1'b0);
    chk("rst_sync", sync, 1'b1);
    chk("rst_flag", flag_t11, 1'b0);

    run = 1'b1;
    run_word(10'h000, 1'b0, 0, 8'h00);
    chk("w0_ia", ia_cap, 8'h00);
    chk("w0_pc", pc, 8'h01);
    chk("w0_iv", inst_valid, 1'b1);
    chk("w0_inst", inst, 10'h000);

    run_word(10'h2B5, 1'b0, 0, 8'h00);
    chk("w1_ia", ia_cap, 8'h01);
    chk("w1_inst", inst, 10'h2B5);
    chk("w1_iv", inst_valid, 1'b1);
    chk("w1_pc", pc, 8'h02);

    run_word(10'h000, 1'b0, 1, 8'hFF);
    chk("w2_ia", ia_cap, 8'h02);
    chk("w2_iv_bt1", iv_at1, 1'b0);
    chk("w2_pc", pc, 8'hFF);
    chk("w2_ack", jmp_ack, 1'b1);

    run_word(10'h000, 1'b0, 0, 8'h00);
    chk("w3_ia", ia_cap, 8'hFF);
    chk("w3_ack_bt1", ack_at1, 1'b0);
    chk("wrap_pc", pc, 8'h00);

    run_word(10'h000, 1'b0, 0, 8'h00);
    chk("wrap_ia", ia_cap, 8'h00);
    chk("w4_pc", pc, 8'h01);
    chk("w4_ack", jmp_ack, 1'b0);

    run_word(10'h000, 1'b0, 1, 8'hA6);
    chk("w5_ia", ia_cap, 8'h01);
    chk("jmp_pc", pc, 8'hA6);
    chk("jmp_ack", jmp_ack, 1'b1);

    run_word(10'h000, 1'b0, 2, 8'h55);
    chk("jmp_ia", ia_cap, 8'hA6);
    chk("ign_pc", pc, 8'hA7);
    chk("ign_ack", jmp_ack, 1'b0);

    run = 1'b0;
    for (int k = 0; k < 3; k++) begin
      run_word(hold_roms[k], 1'b0, 0, 8'h00);
      chk("hold_ia", ia_cap, 8'hA7);
      chk("hold_pc", pc, 8'hA7);
      chk("hold_inst", inst, hold_roms[k]);
      chk("hold_iv", inst_valid, 1'b1);
    end

    run_word(10'h000, 1'b1, 0, 8'h00);
    chk("t11_set", flag_at12, 1'b1);
    run_word(10'h3C3, 1'b0, 0, 8'h00);
    chk("t11_hold", flag_at11, 1'b1);
    chk("t11_clr", flag_at12, 1'b0);
    chk("pre_inst", inst, 10'h3C3);

    // Partial word with t11 set and received bits pending, then reset at bt 50.
    for (int b = 0; b < 50; b++) begin
      is = (b == 11) || (b >= 45);
      cyc();
    end
    is = 1'b0;
    chk("pre_bt", bit_time, 50);
    chk("pre_flag", flag_t11, 1'b1);
    pon = 1'b1;
    cyc();
    pon = 1'b0;
    chk("mrst_bt", bit_time, 0);
    chk("mrst_pc", pc, 8'h00);
    chk("mrst_inst", inst, 10'h000);
    chk("mrst_flag", flag_t11, 1'b0);
    chk("mrst_iv", inst_valid, 1'b0);
    chk("mrst_sync", sync, 1'b1);

    run_word(10'h000, 1'b0, 0, 8'h00);
    chk("post_ia", ia_cap, 8'h00);
    chk("post_pc", pc, 8'h00);
    chk("post_inst", inst, 10'h000);
    chk("post_iv", inst_valid, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
